rf_wb_arb: RTL and testbench
============================

RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 2, which sets the number of queued secondary write entries (power of two, 2..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port wb_we, input, 1 bit: pipeline writeback-stage register-file write enable.
REQ-005 SHALL have port wb_addr, input, 5 bits: pipeline writeback destination register.
REQ-006 SHALL have port wb_data, input, 32 bits: pipeline writeback data.
REQ-007 SHALL have port md_valid, input, 1 bit: secondary (multi-cycle unit) write request.
REQ-008 SHALL have port md_addr, input, 5 bits: secondary destination register.
REQ-009 SHALL have port md_data, input, 32 bits: secondary write data.
REQ-010 SHALL have port md_ready, output, 1 bit: secondary request accepted this cycle.
REQ-011 SHALL have ports rf_we (output, 1 bit), rf_addr (output, 5 bits) and rf_data (output, 32 bits): the registered register-file write port.
REQ-012 SHALL have port pend_mask, output, 32 bits: bit i is set while any valid queued entry targets register i.

Function
REQ-013 SHALL compute md_ready = (queue count < DEPTH), based on registered count only; no same-cycle pop credit.
REQ-014 SHALL define a write as effective only when its enable/valid is high and its address != 0; an md request to $0 SHALL be accepted (md_ready high) and discarded.
REQ-015 SHALL give an effective WB write absolute priority: the next cycle drives rf_we=1, rf_addr=wb_addr, rf_data=wb_data (1-cycle latency).
REQ-016 SHALL, in cycles with no effective WB write and a non-empty queue, pop the head entry to the rf_* outputs the next cycle.
REQ-017 SHALL, with no effective WB write, an empty queue and an effective accepted md request, bypass it directly to the rf_* outputs the next cycle without enqueueing.
REQ-018 SHALL otherwise enqueue an accepted effective md request at the tail, in FIFO order, with pointers wrapping modulo DEPTH.
REQ-019 SHALL drive rf_we=0 next cycle when no write is selected; rf_addr and rf_data SHALL then hold their previous values.
REQ-020 SHALL treat an effective WB write to register r as newer: every valid queued entry with address r is invalidated in that cycle. An invalidated head SHALL be skipped on pop at no cost (no rf write, next valid entry eligible the following cycle).
REQ-021 SHALL NOT enqueue a same-cycle md request whose md_addr equals an effective wb_addr; it is accepted and dropped.
REQ-022 SHALL update pend_mask combinationally from valid queue entries, excluding bypassed requests.

Reset
REQ-023 SHALL, while reset_n=0, immediately clear the queue (count 0, pointers 0, all valid bits 0), rf_we=0, rf_addr=0, rf_data=0 and pend_mask=0; md_ready SHALL be 1.
REQ-024 SHALL discard queued entries on a mid-operation reset; they SHALL never be written.

Configuration
REQ-025 SHALL, when macro RF_WB_ARB_STATS_EN is defined, add outputs stall_cnt (16 bits, counts cycles with md_valid=1 and md_ready=0) and kill_cnt (16 bits, counts entries invalidated per REQ-020/021). Both SHALL saturate at 16'hFFFF and reset to 0.
REQ-026 SHALL, without RF_WB_ARB_STATS_EN, omit those ports and counters, with all other behaviour identical.

Structure
REQ-027 SHALL take the shared header constants REG_ADDR_W=5, DATA_W=32 and REG_ZERO=5'd0 from the codebase's common define file, guarded by an include-once macro.
REQ-028 SHALL place the circular buffer, with per-entry valid bits, address-match invalidate and skip-on-pop, in sub-module rf_wb_fifo; arbitration and output registers SHALL live in rf_wb_arb.

Verification
REQ-029 SHALL cover: wb_we=1, wb_addr=8, wb_data=32'h1234, with md_valid=1, md_addr=9, md_data=32'hAA -> next cycle rf $8=32'h1234, md queued with pend_mask[9]=1; following idle cycle rf $9=32'hAA and pend_mask=0.
REQ-030 SHALL cover: DEPTH=2, wb_we=1 to distinct regs held for 4 cycles while md_valid=1 (regs 3,4,5) -> regs 3 and 4 queued, md_ready=0 on the third request; after wb_we drops, rf writes $3 then $4, then $5 is accepted.
REQ-031 SHALL cover: queue holds $7=32'h1, then wb_we=1, wb_addr=7, wb_data=32'h2 -> rf $7=32'h2, pend_mask[7]=0, and $7 is never rewritten with 32'h1.
REQ-032 SHALL cover: md_valid=1, md_addr=0 with an empty queue -> md_ready=1, rf_we stays 0, and the queue stays empty.
REQ-033 SHALL cover: reset_n pulsed low asynchronously mid-cycle with 2 entries queued -> outputs cleared immediately, no rf writes after release, and md_ready=1.
REQ-034 SHALL cover, with RF_WB_ARB_STATS_EN defined: 3 stall cycles and 1 kill -> stall_cnt=3 and kill_cnt=1.

Source files
------------

// File: rtl/rf_wb_arb_pkg.sv
// Types, constants and helpers shared by the register-file write arbiter
// and its secondary-write queue.
`ifndef RF_WB_ARB_DEFS_SV
`include "rf_wb_arb_defs.sv"
`endif

package rf_wb_arb_pkg;

  localparam int REG_ADDR_W = `REG_ADDR_W;
  localparam int DATA_W     = `DATA_W;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = `REG_ZERO;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  // Source feeding the registered write port in the next cycle.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_WB,
    SEL_POP,
    SEL_BYPASS
  } wr_sel_e;

  // A write only counts when enabled and not aimed at the hardwired zero register.
  function automatic logic is_effective(input logic en, input reg_addr_t addr);
    return en && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/rf_wb_arb_defs.sv
// Shared register-file header constants for the writeback path.
// Include-once guarded so any file may pull it in safely.
`ifndef RF_WB_ARB_DEFS_SV
`define RF_WB_ARB_DEFS_SV

`define REG_ADDR_W 5
`define DATA_W     32
`define REG_ZERO   5'd0

`endif

// File: rtl/rf_wb_fifo.sv
// Circular queue of pending secondary register writes. Each slot carries a
// valid bit so a newer pipeline write can cancel a stale entry in place; a
// cancelled head is still dequeued but reported as not valid.
module rf_wb_fifo
  import rf_wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  reg_addr_t                push_addr,
  input  reg_data_t                push_data,
  input  logic                     pop,
  input  logic                     kill_en,
  input  reg_addr_t                kill_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output reg_addr_t                head_addr,
  output reg_data_t                head_data,
  output logic [NUM_REGS-1:0]      pend_mask,
  output logic [$clog2(DEPTH):0]   kill_num
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] ent_valid;
  reg_addr_t        ent_addr [DEPTH];
  reg_data_t        ent_data [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [DEPTH-1:0] kill_hit;
  logic             do_pop;

  assign do_pop     = pop && (count != '0);
  assign head_valid = ent_valid[head_ptr];
  assign head_addr  = ent_addr[head_ptr];
  assign head_data  = ent_data[head_ptr];

  // Find live entries made stale by a newer write to the same register.
  always_comb begin
    kill_hit = '0;
    kill_num = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_hit[i] = kill_en && ent_valid[i] && (ent_addr[i] == kill_addr);
      kill_num    = kill_num + CNT_W'(kill_hit[i]);
    end
  end

  // Flag every register that still has a live write waiting in the queue.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) pend_mask[ent_addr[i]] = 1'b1;
    end
  end

  // Advance head/tail around the ring and track occupancy, including cancelled slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_pop) head_ptr <= head_ptr + PTR_W'(1);
      if (push)   tail_ptr <= tail_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Valid bits: cancel stale entries, retire the head, then mark the new tail.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_hit[i]) ent_valid[i] <= 1'b0;
      end
      if (do_pop) ent_valid[head_ptr] <= 1'b0;
      if (push)   ent_valid[tail_ptr] <= 1'b1;
    end
  end

  // Payload storage; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail_ptr] <= push_addr;
      ent_data[tail_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/rf_wb_arb.sv
// Register-file write-port arbiter. The pipeline writeback always wins; a
// multi-cycle unit's writes are queued behind it, bypassed straight through
// when the port and queue are idle, and cancelled when the pipeline writes
// the same register later.
// Optional build macro RF_WB_ARB_STATS_EN adds stall_cnt / kill_cnt.
module rf_wb_arb
  import rf_wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0]     md_data,
  output logic                  md_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0]     rf_data,
  output logic [NUM_REGS-1:0]   pend_mask
`ifdef RF_WB_ARB_STATS_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           kill_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [CNT_W-1:0] q_count;
  logic [CNT_W-1:0] kill_num;
  logic             head_valid;
  reg_addr_t        head_addr;
  reg_data_t        head_data;

  logic      wb_eff;
  logic      md_accept;
  logic      md_drop_same;
  logic      do_pop;
  logic      do_push;
  wr_sel_e   sel;
  logic      rf_we_nxt;
  reg_addr_t rf_addr_nxt;
  reg_data_t rf_data_nxt;

  // Readiness looks only at registered occupancy, so a pop this cycle gives no credit.
  assign md_ready = (q_count < DEPTH_CNT);

  rf_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (do_push),
    .push_addr (md_addr),
    .push_data (md_data),
    .pop       (do_pop),
    .kill_en   (wb_eff),
    .kill_addr (wb_addr),
    .count     (q_count),
    .head_valid(head_valid),
    .head_addr (head_addr),
    .head_data (head_data),
    .pend_mask (pend_mask),
    .kill_num  (kill_num)
  );

  // Pick the write source: pipeline first, then queue head, then direct bypass.
  always_comb begin
    wb_eff       = is_effective(wb_we, wb_addr);
    md_accept    = is_effective(md_valid, md_addr) && md_ready;
    md_drop_same = md_accept && wb_eff && (md_addr == wb_addr);
    sel          = SEL_NONE;
    do_pop       = 1'b0;
    do_push      = 1'b0;
    if (wb_eff) begin
      sel     = SEL_WB;
      do_push = md_accept && !md_drop_same;
    end else if (q_count != '0) begin
      sel     = SEL_POP;
      do_pop  = 1'b1;
      do_push = md_accept;
    end else if (md_accept) begin
      sel = SEL_BYPASS;
    end
  end

  // Form next write-port values; address/data hold when nothing is written.
  always_comb begin
    rf_we_nxt   = 1'b0;
    rf_addr_nxt = rf_addr;
    rf_data_nxt = rf_data;
    case (sel)
      SEL_WB: begin
        rf_we_nxt   = 1'b1;
        rf_addr_nxt = wb_addr;
        rf_data_nxt = wb_data;
      end
      SEL_POP: begin
        if (head_valid) begin
          rf_we_nxt   = 1'b1;
          rf_addr_nxt = head_addr;
          rf_data_nxt = head_data;
        end
      end
      SEL_BYPASS: begin
        rf_we_nxt   = 1'b1;
        rf_addr_nxt = md_addr;
        rf_data_nxt = md_data;
      end
      default: ;
    endcase
  end

  // Registered register-file write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      rf_we   <= rf_we_nxt;
      rf_addr <= rf_addr_nxt;
      rf_data <= rf_data_nxt;
    end
  end

`ifdef RF_WB_ARB_STATS_EN
  logic [16:0] kill_sum;

  assign kill_sum = {1'b0, kill_cnt} + 17'(kill_num) + 17'(md_drop_same);

  // Saturating counters of back-pressure cycles and cancelled secondary writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      if (md_valid && !md_ready && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      kill_cnt <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end
  end
`else
  logic unused_kill_num;

  assign unused_kill_num = ^kill_num;
`endif

endmodule

// File: tb/tb_rf_wb_arb.sv
// Directed bench for rf_wb_arb (DEPTH=2): a vector table for single-cycle
// behaviour plus hand sequences for async reset and the optional counters.
module tb_rf_wb_arb;

  logic        clk;
  logic        reset_n;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] pend_mask;
`ifdef RF_WB_ARB_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] kill_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        exp_ready;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [31:0] exp_pend;
  } vec_t;

  vec_t vecs[$];

  rf_wb_arb #(
    .DEPTH(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .md_valid (md_valid),
    .md_addr  (md_addr),
    .md_data  (md_data),
    .md_ready (md_ready),
    .rf_we    (rf_we),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .pend_mask(pend_mask)
`ifdef RF_WB_ARB_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .kill_cnt (kill_cnt)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string name,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic er, input logic ewe, input logic [4:0] ea,
                              input logic [31:0] ed, input logic [31:0] ep);
    vec_t v;
    v.name = name;
    v.wb_we = we;      v.wb_addr = wa;   v.wb_data = wd;
    v.md_valid = mv;   v.md_addr = ma;   v.md_data = md;
    v.exp_ready = er;  v.exp_we = ewe;   v.exp_addr = ea;
    v.exp_data = ed;   v.exp_pend = ep;
    return v;
  endfunction

  task automatic apply_stimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_we    = we;
    wb_addr  = wa;
    wb_data  = wd;
    md_valid = mv;
    md_addr  = ma;
    md_data  = md;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hang guard.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    reset_n = 1'b1;
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #3 reset_n = 1'b0;
    #1;
    check_output("reset_rf_we",   32'(rf_we),    32'h0);
    check_output("reset_rf_addr", 32'(rf_addr),  32'h0);
    check_output("reset_rf_data", rf_data,       32'h0);
    check_output("reset_pend",    pend_mask,     32'h0);
    check_output("reset_ready",   32'(md_ready), 32'h1);
    @(posedge clk);
    #1 reset_n = 1'b1;

    //                name            we wa     wd            mv ma     md            rdy we  ea     ed            pend
    vecs.push_back(mk("wb8_md9",      1, 5'd8,  32'h1234,     1, 5'd9,  32'hAA,       1,  1, 5'd8,  32'h1234,     32'h0000_0200));
    vecs.push_back(mk("pop9",         0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  1, 5'd9,  32'hAA,       32'h0));
    vecs.push_back(mk("idle_hold",    0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  0, 5'd9,  32'hAA,       32'h0));
    vecs.push_back(mk("md_r0",        0, 5'd0,  32'h0,        1, 5'd0,  32'h55,       1,  0, 5'd9,  32'hAA,       32'h0));
    vecs.push_back(mk("md_r0_after",  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  0, 5'd9,  32'hAA,       32'h0));
    vecs.push_back(mk("bypass6",      0, 5'd0,  32'h0,        1, 5'd6,  32'h66,       1,  1, 5'd6,  32'h66,       32'h0));
    vecs.push_back(mk("wb10_md3",     1, 5'd10, 32'hA0,       1, 5'd3,  32'h33,       1,  1, 5'd10, 32'hA0,       32'h0000_0008));
    vecs.push_back(mk("wb11_md4",     1, 5'd11, 32'hB0,       1, 5'd4,  32'h44,       1,  1, 5'd11, 32'hB0,       32'h0000_0018));
    vecs.push_back(mk("wb12_full",    1, 5'd12, 32'hC0,       1, 5'd5,  32'h55,       0,  1, 5'd12, 32'hC0,       32'h0000_0018));
    vecs.push_back(mk("wb13_full",    1, 5'd13, 32'hD0,       1, 5'd5,  32'h55,       0,  1, 5'd13, 32'hD0,       32'h0000_0018));
    vecs.push_back(mk("pop3_full",    0, 5'd0,  32'h0,        1, 5'd5,  32'h55,       0,  1, 5'd3,  32'h33,       32'h0000_0010));
    vecs.push_back(mk("pop4_acc5",    0, 5'd0,  32'h0,        1, 5'd5,  32'h55,       1,  1, 5'd4,  32'h44,       32'h0000_0020));
    vecs.push_back(mk("pop5",         0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  1, 5'd5,  32'h55,       32'h0));
    vecs.push_back(mk("wb14_md7",     1, 5'd14, 32'hE0,       1, 5'd7,  32'h1,        1,  1, 5'd14, 32'hE0,       32'h0000_0080));
    vecs.push_back(mk("wb7_kill",     1, 5'd7,  32'h2,        0, 5'd0,  32'h0,        1,  1, 5'd7,  32'h2,        32'h0));
    vecs.push_back(mk("skip_dead",    0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  0, 5'd7,  32'h2,        32'h0));
    vecs.push_back(mk("after_skip",   0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  0, 5'd7,  32'h2,        32'h0));
    vecs.push_back(mk("same_reg",     1, 5'd20, 32'hF0,       1, 5'd20, 32'h99,       1,  1, 5'd20, 32'hF0,       32'h0));
    vecs.push_back(mk("same_after",   0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  0, 5'd20, 32'hF0,       32'h0));
    vecs.push_back(mk("wb_r0",        1, 5'd0,  32'hDEAD,     0, 5'd0,  32'h0,        1,  0, 5'd20, 32'hF0,       32'h0));
    vecs.push_back(mk("wb_r0_byp21",  1, 5'd0,  32'hBEEF,     1, 5'd21, 32'h2121,     1,  1, 5'd21, 32'h2121,     32'h0));
    vecs.push_back(mk("idle_end",     0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  0, 5'd21, 32'h2121,     32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].wb_we, vecs[i].wb_addr, vecs[i].wb_data,
                     vecs[i].md_valid, vecs[i].md_addr, vecs[i].md_data);
      #1;
      check_output({vecs[i].name, "_ready"}, 32'(md_ready), 32'(vecs[i].exp_ready));
      tick();
      check_output({vecs[i].name, "_we"},   32'(rf_we),   32'(vecs[i].exp_we));
      check_output({vecs[i].name, "_addr"}, 32'(rf_addr), 32'(vecs[i].exp_addr));
      check_output({vecs[i].name, "_data"}, rf_data,      vecs[i].exp_data);
      check_output({vecs[i].name, "_pend"}, pend_mask,    vecs[i].exp_pend);
    end

    // Mid-cycle asynchronous reset with two entries queued.
    apply_stimulus(1'b1, 5'd15, 32'hF15, 1'b1, 5'd16, 32'h16);
    tick();
    apply_stimulus(1'b1, 5'd17, 32'hF17, 1'b1, 5'd18, 32'h18);
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_output("prerst_pend",  pend_mask,     32'h0005_0000);
    check_output("prerst_ready", 32'(md_ready), 32'h0);
    check_output("prerst_we",    32'(rf_we),    32'h1);
    #2 reset_n = 1'b0;
    #1;
    check_output("arst_we",    32'(rf_we),    32'h0);
    check_output("arst_addr",  32'(rf_addr),  32'h0);
    check_output("arst_data",  rf_data,       32'h0);
    check_output("arst_pend",  pend_mask,     32'h0);
    check_output("arst_ready", 32'(md_ready), 32'h1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_output("postrst_we",   32'(rf_we),   32'h0);
      check_output("postrst_addr", 32'(rf_addr), 32'h0);
    end
    check_output("postrst_ready", 32'(md_ready), 32'h1);

`ifdef RF_WB_ARB_STATS_EN
    // Fill the queue, stall three cycles, and cancel one queued entry.
    apply_stimulus(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23);
    tick();
    apply_stimulus(1'b1, 5'd24, 32'h24, 1'b1, 5'd25, 32'h25);
    tick();
    apply_stimulus(1'b1, 5'd26, 32'h26, 1'b1, 5'd29, 32'h29);
    tick();
    apply_stimulus(1'b1, 5'd27, 32'h27, 1'b1, 5'd29, 32'h29);
    tick();
    apply_stimulus(1'b1, 5'd23, 32'h123, 1'b1, 5'd29, 32'h29);
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_output("stats_pend", pend_mask, 32'h0200_0000);
    for (int c = 0; c < 3; c++) tick();
    check_output("stall_cnt", 32'(stall_cnt), 32'd3);
    check_output("kill_cnt",  32'(kill_cnt),  32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
